ex_div_ctrl: RTL and testbench
==============================

Name: ex_div_ctrl

Overview:
Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU, attached beside the single-cycle EX ALU.
- Accepts a divide request from EX.
- Raises a stall request to the pipeline controller while it iterates.
- Runs a radix-2 restoring divider for XLEN cycles, then hands a signed-corrected result to EX for EX/MEM writeback.
- A flush (annul) from the pipeline controller aborts it at any time.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
start_i  in  1  EX holds a div-class instruction. Level, held by EX while stalled.
op_i  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU. Sampled at accept.
dividend_i  in  XLEN  rs1 value. Sampled at accept.
divisor_i  in  XLEN  rs2 value. Sampled at accept.
annul_i  in  1  flush from the pipeline controller. Highest priority after reset.
stall_req_o  out  1  request to freeze IF/ID/EX.
result_o  out  XLEN  quotient or remainder. Valid while done_o=1, held until the next accept.
done_o  out  1  one-cycle pulse; result_o is valid and EX may write it back.
busy_o  out  1  state is not IDLE.

Behaviour:
Reset (rst_n=0, async):
- state=IDLE, counter=0, all datapath registers 0.
- result_o=0, done_o=0, busy_o=0, stall_req_o=0.
- Reset mid-operation discards the division silently; no done pulse is produced.

States: IDLE, CALC, FIXUP, DONE. All outputs other than stall_req_o are registered.

IDLE:
- An edge with start_i=1 and annul_i=0 is the accept edge.
- Latch op, operand magnitudes, sign flags and the special-case flags.
- Divisor==0 or signed overflow: go to DONE, with result_o loaded on the same edge.
- Otherwise: go to CALC with counter=0.

CALC, one iteration per edge:
- Shift {rem, quo} left by 1.
- 33-bit trial = rem - |divisor|.
- If non-negative: rem = trial and quo[0] = 1.
- counter increments; after iteration XLEN-1, go to FIXUP.

FIXUP:
- Signed ops: quotient is negated iff the operand signs differ; remainder takes the sign of the dividend.
- Load result_o with the quotient (DIV/DIVU) or the remainder (REM/REMU).
- Go to DONE.

DONE:
- done_o=1 for exactly this cycle. Next edge goes to IDLE unconditionally.
- start_i is ignored here, because EX still presents the same instruction in this cycle.

stall_req_o (combinational):
- Equals (IDLE and start_i) or CALC or FIXUP.
- Forced to 0 whenever annul_i=1.
- Always 0 in DONE, so the pipeline advances with the result.

Latency:
- Normal case: accept edge, XLEN CALC edges, 1 FIXUP edge, so done_o is high in the cycle after edge XLEN+1. That is 34 cycles from the start cycle at XLEN=32.
- Special cases: done_o is high in the cycle immediately after accept (latency 1).

Special results (RISC-V spec):
- Divide by zero: quotient = all ones; remainder = dividend (unsigned and signed alike).
- Overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.

annul_i=1 at an edge:
- From any state, next state is IDLE, counter is cleared and done_o=0.
- result_o keeps its previous value.
- Annul on the accept edge means no accept takes place.
- Simultaneous annul_i and start_i in IDLE: annul wins.

Width rules:
- Magnitudes are XLEN-bit unsigned; |0x80000000| is 0x80000000 as unsigned.
- The trial subtract is XLEN+1 bits; the borrow bit decides restore.

Decomposition:
- The shared macro header gets: op encodings (DivOp_DIV/DIVU/REM/REMU), state encodings (DivIdle, DivCalc, DivFixup, DivDone), and DivAllOnes / DivMinNeg constants.
- One sub-module, div_step: combinational shift/trial-subtract of one iteration (rem, quo, divisor in; rem, quo out).
- The FSM, sign handling and special cases stay in ex_div_ctrl.

Test Plan:
- DIVU 100/7: stall_req_o high from the start cycle to the cycle before done. done_o pulses at cycle 34 with result_o=14. REMU of the same operands gives 2.
- DIV -7/2: result_o=0xFFFFFFFD (-3). REM -7/2: result_o=0xFFFFFFFF (-1). DIV 7/-2: result_o=0xFFFFFFFD.
- DIV 5/0: done_o at cycle 1 with 0xFFFFFFFF. REMU 5/0 gives 5. DIV 0x80000000/0xFFFFFFFF gives 0x80000000 at cycle 1; REM of the same gives 0.
- Start DIVU 1000/10, assert annul_i at cycle 10:
  - stall_req_o drops that cycle and busy_o clears the next cycle.
  - No done_o pulse occurs; result_o is unchanged.
  - A new start of DIVU 9/3 then completes with 3 at latency 34.
- Hold start_i high through DONE: exactly one done_o pulse, and no re-accept in DONE.
- Drop rst_n at cycle 20 mid-CALC: all outputs go 0 immediately (asynchronously), and the FSM stays in IDLE after release until the next start.

Source files
------------

// File: rtl/ex_div_ctrl_pkg.sv
// Shared encodings and constants for the RV32M divide sequencer.
package ex_div_ctrl_pkg;

    localparam int DIV_XLEN = 32;

    typedef enum logic [1:0] {
        DivOp_DIV  = 2'b00,
        DivOp_DIVU = 2'b01,
        DivOp_REM  = 2'b10,
        DivOp_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DivIdle  = 2'b00,
        DivCalc  = 2'b01,
        DivFixup = 2'b10,
        DivDone  = 2'b11
    } div_state_e;

    localparam logic [DIV_XLEN-1:0] DivAllOnes = {DIV_XLEN{1'b1}};
    localparam logic [DIV_XLEN-1:0] DivMinNeg  = {1'b1, {(DIV_XLEN-1){1'b0}}};

endpackage

// File: rtl/ex_div_ctrl_div_step.sv
// One radix-2 restoring divide iteration: shift {rem, quo} left, trial-subtract, restore on borrow.
module ex_div_ctrl_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        trial   = shifted - {1'b0, dvs_i};
        // MSB of the XLEN+1-bit trial is the borrow; set means restore.
        if (!trial[XLEN]) begin
            rem_o = trial[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = shifted[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_div_ctrl.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer beside the EX ALU; stalls the pipe while iterating.
module ex_div_ctrl
    import ex_div_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            annul_i,
    output logic            stall_req_o,
    output logic [XLEN-1:0] result_o,
    output logic            done_o,
    output logic            busy_o
);

    div_state_e      state_q, state_d;
    div_op_e         op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic            done_q, done_d;

    logic [XLEN-1:0] step_rem, step_quo;
    logic            is_signed, sgn_a, sgn_b, div_zero, ovf, is_rem;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    ex_div_ctrl_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Operand decode at accept; magnitudes stay unsigned so |MIN| is representable.
    always_comb begin
        is_signed   = ~op_i[0];
        is_rem      = op_i[1];
        sgn_a       = is_signed & dividend_i[XLEN-1];
        sgn_b       = is_signed & divisor_i[XLEN-1];
        mag_a       = sgn_a ? (~dividend_i + 1'b1) : dividend_i;
        mag_b       = sgn_b ? (~divisor_i + 1'b1) : divisor_i;
        div_zero    = (divisor_i == '0);
        ovf         = is_signed && (dividend_i == XLEN'(DivMinNeg)) && (divisor_i == XLEN'(DivAllOnes));
        special_res = '0;
        if (div_zero)
            special_res = is_rem ? dividend_i : XLEN'(DivAllOnes);
        else if (ovf)
            special_res = is_rem ? '0 : XLEN'(DivMinNeg);
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        done_d    = 1'b0;
        if (annul_i) begin
            state_d = DivIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DivIdle: begin
                    if (start_i) begin
                        op_d      = div_op_e'(op_i);
                        neg_quo_d = sgn_a ^ sgn_b;
                        neg_rem_d = sgn_a;
                        rem_d     = '0;
                        quo_d     = mag_a;
                        dvs_d     = mag_b;
                        cnt_d     = '0;
                        if (div_zero || ovf) begin
                            result_d = special_res;
                            done_d   = 1'b1;
                            state_d  = DivDone;
                        end else begin
                            state_d = DivCalc;
                        end
                    end
                end
                DivCalc: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN-1))
                        state_d = DivFixup;
                end
                DivFixup: begin
                    if (op_q == DivOp_REM || op_q == DivOp_REMU)
                        result_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
                    else
                        result_d = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
                    done_d  = 1'b1;
                    state_d = DivDone;
                end
                default: state_d = DivIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DivIdle;
            op_q      <= DivOp_DIV;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    // Gated by rst_n so a held start_i cannot raise a stall while in reset.
    assign stall_req_o = rst_n & ~annul_i &
                         (((state_q == DivIdle) & start_i) | (state_q == DivCalc) | (state_q == DivFixup));
    assign result_o    = result_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q != DivIdle);

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed-vector bench for ex_div_ctrl with hand-computed results and latencies.
module tb_ex_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        annul_i;
    logic        stall_req_o;
    logic [31:0] result_o;
    logic        done_o;
    logic        busy_o;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_res = 32'h0;

    ex_div_ctrl #(.XLEN(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .op_i        (op_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .annul_i     (annul_i),
        .stall_req_o (stall_req_o),
        .result_o    (result_o),
        .done_o      (done_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; that cycle is the start cycle (cycle 0).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string tag);
        int   cyc;
        logic seen;
        logic stall_ok;
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        #1;
        stall_ok = (stall_req_o === 1'b1);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            step();
            cyc++;
            if (done_o === 1'b1) seen = 1'b1;
            else if (stall_req_o !== 1'b1) stall_ok = 1'b0;
        end
        check_eq({tag, "_latency"}, 32'(cyc), 32'(lat));
        check_eq({tag, "_result"}, result_o, exp);
        check_eq({tag, "_stall_in_done"}, 32'(stall_req_o), 32'h0);
        check_eq({tag, "_stall_until_done"}, 32'(stall_ok), 32'h1);
        // start_i stays high across the DONE edge: must not re-accept.
        step();
        check_eq({tag, "_single_pulse"}, 32'(done_o), 32'h0);
        check_eq({tag, "_no_reaccept"}, 32'(busy_o), 32'h0);
        start_i  = 1'b0;
        last_res = exp;
    endtask

    initial begin
        int done_seen;
        rst_n      = 1'b0;
        start_i    = 1'b0;
        op_i       = 2'b00;
        dividend_i = 32'h0;
        divisor_i  = 32'h0;
        annul_i    = 1'b0;
        #1;
        check_eq("rst_result", result_o, 32'h0);
        check_eq("rst_done", 32'(done_o), 32'h0);
        check_eq("rst_busy", 32'(busy_o), 32'h0);
        check_eq("rst_stall", 32'(stall_req_o), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();

        run_op(2'b01, 32'd100, 32'd7, 32'd14, 34, "divu_100_7");
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 34, "remu_100_7");
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_m7_2");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_m7_2");
        run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div_7_m2");
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, "rem_7_m2");
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, "divu_max_1");
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, "divu_min_ones");
        run_op(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_5_0");
        run_op(2'b11, 32'd5, 32'd0, 32'd5, 1, "remu_5_0");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, "rem_m7_0");
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");

        // Annul at cycle 10 of a running DIVU 1000/10.
        op_i       = 2'b01;
        dividend_i = 32'd1000;
        divisor_i  = 32'd10;
        start_i    = 1'b1;
        repeat (10) step();
        check_eq("annul_busy_before", 32'(busy_o), 32'h1);
        annul_i = 1'b1;
        #1;
        check_eq("annul_stall_drop", 32'(stall_req_o), 32'h0);
        step();
        annul_i = 1'b0;
        start_i = 1'b0;
        check_eq("annul_busy_clear", 32'(busy_o), 32'h0);
        check_eq("annul_done", 32'(done_o), 32'h0);
        check_eq("annul_result_kept", result_o, last_res);
        done_seen = 0;
        repeat (40) begin
            step();
            if (done_o === 1'b1) done_seen++;
        end
        check_eq("annul_no_done", 32'(done_seen), 32'h0);
        run_op(2'b01, 32'd9, 32'd3, 32'd3, 34, "divu_9_3_after_annul");

        // Async reset at cycle 20 mid-CALC with start_i still held.
        op_i       = 2'b01;
        dividend_i = 32'd1000;
        divisor_i  = 32'd10;
        start_i    = 1'b1;
        repeat (20) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_result", result_o, 32'h0);
        check_eq("arst_done", 32'(done_o), 32'h0);
        check_eq("arst_busy", 32'(busy_o), 32'h0);
        check_eq("arst_stall", 32'(stall_req_o), 32'h0);
        step();
        start_i = 1'b0;
        step();
        rst_n = 1'b1;
        done_seen = 0;
        repeat (5) begin
            step();
            if (done_o === 1'b1 || busy_o === 1'b1) done_seen++;
        end
        check_eq("arst_stays_idle", 32'(done_seen), 32'h0);
        run_op(2'b01, 32'd100, 32'd7, 32'd14, 34, "divu_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
